mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and produces the MEM/WB bundle.

---
 rtl/mem_stage_lsu_if.sv | 16 +
 rtl/mem_stage_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage LSU (master) and a
// variable-latency data memory (slave).
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata, output be,
                  input  rdata, input ack);
  modport slave  (input  req, input  we, input  addr, input  wdata, input  be,
                  output rdata, output ack);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane steering, WB store-data forwarding, req/ack
// handshake to data memory with a timeout, and the MEM/WB result register.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_alu_out,
  input  logic [31:0]            mem_store_data,
  input  logic [4:0]             mem_rt,
  input  logic [4:0]             mem_rd,
  input  logic [5:0]             mem_ctr,
  input  logic [31:0]            fwd_data,
  input  logic [4:0]             fwd_rd,
  input  logic                   fwd_we,
  mem_stage_lsu_if.master        dm,
  output logic                   stall,
  output logic                   memwb_valid,
  output logic [31:0]            memwb_data,
  output logic [4:0]             memwb_rd,
  output logic                   memwb_regwrite,
  output logic [1:0]             memwb_exc
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        req_reg, req_next, we_reg, we_next;
  logic [31:0] addr_reg, addr_next, wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic [4:0]  acc_rd_reg, acc_rd_next;
  logic [1:0]  acc_size_reg, acc_size_next, acc_off_reg, acc_off_next;
  logic        acc_sign_reg, acc_sign_next, acc_rw_reg, acc_rw_next;
  logic        memwb_valid_reg, memwb_valid_next, memwb_regwrite_reg, memwb_regwrite_next;
  logic [31:0] memwb_data_reg, memwb_data_next;
  logic [4:0]  memwb_rd_reg, memwb_rd_next;
  logic [1:0]  memwb_exc_reg, memwb_exc_next;

  logic        is_mem, aligned, fwd_hit, timeout_hit;
  logic [31:0] st_data, wdata_c, load_val;
  logic [3:0]  be_c;
  logic [7:0]  rd_byte [4];
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign is_mem      = mem_ctr[5] | mem_ctr[4];
  assign fwd_hit     = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == mem_rt);
  assign st_data     = fwd_hit ? fwd_data : mem_store_data;
  // A zero limit disables the timeout entirely.
  assign timeout_hit = (TO_LIM != 8'd0) && (cnt_reg == TO_LIM - 8'd1);

  always_comb begin
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = st_data;
    case (mem_ctr[3:2])
      2'b00: begin
        be_c    = 4'b0001 << mem_alu_out[1:0];
        wdata_c = {4{st_data[7:0]}};
      end
      2'b01: begin
        aligned = ~mem_alu_out[0];
        be_c    = mem_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_data[15:0]}};
      end
      default: aligned = (mem_alu_out[1:0] == 2'b00);
    endcase
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = dm.rdata[8*gi +: 8];
  end

  assign ld_b = rd_byte[acc_off_reg];
  assign ld_h = acc_off_reg[1] ? dm.rdata[31:16] : dm.rdata[15:0];

  always_comb begin
    case (acc_size_reg)
      2'b00:   load_val = acc_sign_reg ? {{24{ld_b[7]}}, ld_b} : {24'd0, ld_b};
      2'b01:   load_val = acc_sign_reg ? {{16{ld_h[15]}}, ld_h} : {16'd0, ld_h};
      default: load_val = dm.rdata;
    endcase
  end

  always_comb begin
    state_next          = state_reg;
    stall               = 1'b0;
    cnt_next            = cnt_reg;
    req_next            = req_reg;
    we_next             = we_reg;
    addr_next           = addr_reg;
    wdata_next          = wdata_reg;
    be_next             = be_reg;
    acc_rd_next         = acc_rd_reg;
    acc_size_next       = acc_size_reg;
    acc_off_next        = acc_off_reg;
    acc_sign_next       = acc_sign_reg;
    acc_rw_next         = acc_rw_reg;
    memwb_valid_next    = 1'b0;
    memwb_data_next     = memwb_data_reg;
    memwb_rd_next       = memwb_rd_reg;
    memwb_regwrite_next = memwb_regwrite_reg;
    memwb_exc_next      = memwb_exc_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (mem_valid) begin
          if (!is_mem) begin
            memwb_valid_next    = 1'b1;
            memwb_data_next     = mem_alu_out;
            memwb_rd_next       = mem_rd;
            memwb_regwrite_next = mem_ctr[0];
            memwb_exc_next      = 2'b00;
          end else if (!aligned) begin
            memwb_valid_next    = 1'b1;
            memwb_data_next     = mem_alu_out;
            memwb_rd_next       = mem_rd;
            memwb_regwrite_next = 1'b0;
            memwb_exc_next      = 2'b01;
          end else begin
            stall         = 1'b1;
            state_next    = BUSY;
            req_next      = 1'b1;
            we_next       = mem_ctr[4];
            addr_next     = {mem_alu_out[31:2], 2'b00};
            be_next       = be_c;
            wdata_next    = wdata_c;
            acc_rd_next   = mem_rd;
            acc_size_next = mem_ctr[3:2];
            acc_off_next  = mem_alu_out[1:0];
            acc_sign_next = mem_ctr[1];
            acc_rw_next   = mem_ctr[0];
          end
        end
      end
      BUSY: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (dm.ack) begin
          state_next          = IDLE;
          req_next            = 1'b0;
          memwb_valid_next    = 1'b1;
          memwb_rd_next       = acc_rd_reg;
          memwb_exc_next      = 2'b00;
          memwb_data_next     = we_reg ? 32'd0 : load_val;
          memwb_regwrite_next = we_reg ? 1'b0 : acc_rw_reg;
        end else if (timeout_hit) begin
          state_next          = IDLE;
          req_next            = 1'b0;
          memwb_valid_next    = 1'b1;
          memwb_rd_next       = acc_rd_reg;
          memwb_exc_next      = 2'b10;
          memwb_data_next     = 32'd0;
          memwb_regwrite_next = 1'b0;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      cnt_reg            <= 8'd0;
      req_reg            <= 1'b0;
      we_reg             <= 1'b0;
      addr_reg           <= 32'd0;
      wdata_reg          <= 32'd0;
      be_reg             <= 4'd0;
      acc_rd_reg         <= 5'd0;
      acc_size_reg       <= 2'd0;
      acc_off_reg        <= 2'd0;
      acc_sign_reg       <= 1'b0;
      acc_rw_reg         <= 1'b0;
      memwb_valid_reg    <= 1'b0;
      memwb_data_reg     <= 32'd0;
      memwb_rd_reg       <= 5'd0;
      memwb_regwrite_reg <= 1'b0;
      memwb_exc_reg      <= 2'd0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      req_reg            <= req_next;
      we_reg             <= we_next;
      addr_reg           <= addr_next;
      wdata_reg          <= wdata_next;
      be_reg             <= be_next;
      acc_rd_reg         <= acc_rd_next;
      acc_size_reg       <= acc_size_next;
      acc_off_reg        <= acc_off_next;
      acc_sign_reg       <= acc_sign_next;
      acc_rw_reg         <= acc_rw_next;
      memwb_valid_reg    <= memwb_valid_next;
      memwb_data_reg     <= memwb_data_next;
      memwb_rd_reg       <= memwb_rd_next;
      memwb_regwrite_reg <= memwb_regwrite_next;
      memwb_exc_reg      <= memwb_exc_next;
    end
  end

  assign dm.req         = req_reg;
  assign dm.we          = we_reg;
  assign dm.addr        = addr_reg;
  assign dm.wdata       = wdata_reg;
  assign dm.be          = be_reg;
  assign memwb_valid    = memwb_valid_reg;
  assign memwb_data     = memwb_data_reg;
  assign memwb_rd       = memwb_rd_reg;
  assign memwb_regwrite = memwb_regwrite_reg;
  assign memwb_exc      = memwb_exc_reg;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, loads, stores with forwarding,
// misalignment, timeout and reset during an outstanding access.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_alu_out, mem_store_data, fwd_data;
  logic [4:0]  mem_rt, mem_rd, fwd_rd;
  logic [5:0]  mem_ctr;
  logic        fwd_we;
  logic        stall, memwb_valid, memwb_regwrite;
  logic [31:0] memwb_data;
  logic [4:0]  memwb_rd;
  logic [1:0]  memwb_exc;
  int          checks = 0;
  int          errors = 0;

  mem_stage_lsu_if dm_bus ();

  mem_stage_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_rt         (mem_rt),
    .mem_rd         (mem_rd),
    .mem_ctr        (mem_ctr),
    .fwd_data       (fwd_data),
    .fwd_rd         (fwd_rd),
    .fwd_we         (fwd_we),
    .dm             (dm_bus.master),
    .stall          (stall),
    .memwb_valid    (memwb_valid),
    .memwb_data     (memwb_data),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_exc      (memwb_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_alu_out = '0; mem_store_data = '0; mem_rt = '0;
    mem_rd = '0; mem_ctr = '0; fwd_data = '0; fwd_rd = '0; fwd_we = 1'b0;
    dm_bus.rdata = '0; dm_bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc, memwb_rd} !== 9'd0) begin errors++;
      $display("FAIL reset_memwb_ctl: got %h expected 000", {memwb_valid, memwb_regwrite, memwb_exc, memwb_rd}); end
    checks++; if (memwb_data !== 32'd0) begin errors++;
      $display("FAIL reset_memwb_data: got %h expected 00000000", memwb_data); end
    checks++; if ({dm_bus.req, dm_bus.we, dm_bus.be} !== 6'd0) begin errors++;
      $display("FAIL reset_dm_ctl: got %h expected 00", {dm_bus.req, dm_bus.we, dm_bus.be}); end
    checks++; if ({dm_bus.addr, dm_bus.wdata} !== 64'd0) begin errors++;
      $display("FAIL reset_dm_data: got %h expected 0", {dm_bus.addr, dm_bus.wdata}); end
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b expected 0", stall); end
    @(negedge clk); reset = 1'b1;
    $display("txn reset: outputs checked while reset asserted");
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b000001; mem_alu_out = 32'h0000_1234; mem_rd = 5'd8;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL pass_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc, memwb_rd} !== {1'b1, 1'b1, 2'b00, 5'd8}) begin errors++;
      $display("FAIL pass_ctl: got %b%b%b%h expected 11008", memwb_valid, memwb_regwrite, memwb_exc, memwb_rd); end
    checks++; if (memwb_data !== 32'h0000_1234) begin errors++;
      $display("FAIL pass_data: got %h expected 00001234", memwb_data); end
    checks++; if (dm_bus.req !== 1'b0) begin errors++;
      $display("FAIL pass_req: got %b expected 0", dm_bus.req); end
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (memwb_valid !== 1'b0) begin errors++;
      $display("FAIL idle_valid: got %b expected 0", memwb_valid); end
    $display("txn pass-through: alu_out=00001234 rd=8");
  endtask

  task automatic test_lb_signed();
    int sc = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b100011; mem_alu_out = 32'h0000_0103; mem_rd = 5'd5;
    #1; if (stall) sc++;
    @(posedge clk); #1;
    checks++; if ({dm_bus.req, dm_bus.we, dm_bus.be} !== 6'b10_1000) begin errors++;
      $display("FAIL lb_req: got %b expected 101000", {dm_bus.req, dm_bus.we, dm_bus.be}); end
    checks++; if (dm_bus.addr !== 32'h0000_0100) begin errors++;
      $display("FAIL lb_addr: got %h expected 00000100", dm_bus.addr); end
    checks++; if (memwb_valid !== 1'b0) begin errors++;
      $display("FAIL lb_bubble: got %b expected 0", memwb_valid); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (stall) sc++; end
    @(negedge clk); dm_bus.ack = 1'b1; dm_bus.rdata = 32'h80FF_FF7F;
    #1; if (stall) sc++;
    @(posedge clk); #1; dm_bus.ack = 1'b0;
    checks++; if (memwb_data !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb_data: got %h expected ffffff80", memwb_data); end
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc, memwb_rd} !== {1'b1, 1'b1, 2'b00, 5'd5}) begin errors++;
      $display("FAIL lb_ctl: got %b%b%b%h expected 11005", memwb_valid, memwb_regwrite, memwb_exc, memwb_rd); end
    checks++; if (dm_bus.req !== 1'b0) begin errors++;
      $display("FAIL lb_req_drop: got %b expected 0", dm_bus.req); end
    checks++; if (sc != 4) begin errors++;
      $display("FAIL lb_stall_cycles: got %0d expected 4", sc); end
    @(negedge clk); clear_inputs();
    $display("txn lb signed: addr=00000103 rdata=80ffff7f");
  endtask

  task automatic test_lhu();
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b100101; mem_alu_out = 32'h0000_0102; mem_rd = 5'd6;
    @(posedge clk); #1;
    checks++; if (dm_bus.be !== 4'b1100) begin errors++;
      $display("FAIL lhu_be: got %b expected 1100", dm_bus.be); end
    @(negedge clk); dm_bus.ack = 1'b1; dm_bus.rdata = 32'h80FF_1234;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL lhu_ack_stall: got %b expected 0", stall); end
    @(posedge clk); #1; dm_bus.ack = 1'b0;
    checks++; if (memwb_data !== 32'h0000_80FF) begin errors++;
      $display("FAIL lhu_data: got %h expected 000080ff", memwb_data); end
    @(negedge clk); clear_inputs();
    $display("txn lhu: addr=00000102 rdata=80ff1234");
  endtask

  task automatic test_store_forward();
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b010100; mem_alu_out = 32'h0000_0202; mem_rt = 5'd9;
    mem_store_data = 32'h1111_2222; fwd_rd = 5'd9; fwd_we = 1'b1; fwd_data = 32'h0000_ABCD;
    @(posedge clk); #1;
    checks++; if ({dm_bus.req, dm_bus.we, dm_bus.be} !== 6'b11_1100) begin errors++;
      $display("FAIL sh_req: got %b expected 111100", {dm_bus.req, dm_bus.we, dm_bus.be}); end
    checks++; if (dm_bus.addr !== 32'h0000_0200) begin errors++;
      $display("FAIL sh_addr: got %h expected 00000200", dm_bus.addr); end
    checks++; if (dm_bus.wdata !== 32'hABCD_ABCD) begin errors++;
      $display("FAIL sh_wdata: got %h expected abcdabcd", dm_bus.wdata); end
    @(negedge clk); dm_bus.ack = 1'b1;
    @(posedge clk); #1; dm_bus.ack = 1'b0;
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc} !== 4'b1000) begin errors++;
      $display("FAIL sh_done: got %b expected 1000", {memwb_valid, memwb_regwrite, memwb_exc}); end
    $display("txn sh fwd: addr=00000202 fwd_data=0000abcd");
    // SB with rt=r0: forwarding must not fire even though fwd_rd matches
    @(negedge clk);
    mem_ctr = 6'b010000; mem_alu_out = 32'h0000_0201; mem_rt = 5'd0; fwd_rd = 5'd0;
    mem_store_data = 32'h0000_005A;
    @(posedge clk); #1;
    checks++; if ({dm_bus.be, dm_bus.wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++;
      $display("FAIL sb_lane: got %b %h expected 0010 5a5a5a5a", dm_bus.be, dm_bus.wdata); end
    @(negedge clk);
    @(negedge clk); dm_bus.ack = 1'b1;
    @(posedge clk); #1; dm_bus.ack = 1'b0;
    checks++; if (dm_bus.req !== 1'b0 || memwb_valid !== 1'b1) begin errors++;
      $display("FAIL sb_done: got req=%b valid=%b expected req=0 valid=1", dm_bus.req, memwb_valid); end
    @(negedge clk); clear_inputs();
    $display("txn sb r0: addr=00000201 data=0000005a");
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b101001; mem_alu_out = 32'h0000_00FE; mem_rd = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL mis_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    checks++; if (dm_bus.req !== 1'b0) begin errors++;
      $display("FAIL mis_req: got %b expected 0", dm_bus.req); end
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc} !== 4'b1001) begin errors++;
      $display("FAIL mis_exc: got %b expected 1001", {memwb_valid, memwb_regwrite, memwb_exc}); end
    @(negedge clk); clear_inputs();
    $display("txn lw misaligned: addr=000000fe");
  endtask

  task automatic test_timeout();
    int hi = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b101001; mem_alu_out = 32'h0000_0300; mem_rd = 5'd7;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (stall && dm_bus.req) hi++; end
    checks++; if (hi != 3) begin errors++;
      $display("FAIL to_wait: got %0d stalled cycles expected 3", hi); end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0 || dm_bus.req !== 1'b1) begin errors++;
      $display("FAIL to_last: got stall=%b req=%b expected stall=0 req=1", stall, dm_bus.req); end
    @(posedge clk); #1;
    checks++; if (dm_bus.req !== 1'b0) begin errors++;
      $display("FAIL to_req: got %b expected 0", dm_bus.req); end
    checks++; if ({memwb_valid, memwb_regwrite, memwb_exc} !== 4'b1010) begin errors++;
      $display("FAIL to_exc: got %b expected 1010", {memwb_valid, memwb_regwrite, memwb_exc}); end
    @(negedge clk); clear_inputs();
    $display("txn lw timeout: addr=00000300");
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    mem_valid = 1'b1; mem_ctr = 6'b101001; mem_alu_out = 32'h0000_0400; mem_rd = 5'd4;
    @(posedge clk);
    @(negedge clk); reset = 1'b0; mem_valid = 1'b0;
    #1;
    checks++; if ({dm_bus.req, stall, memwb_valid, dm_bus.be} !== 7'd0) begin errors++;
      $display("FAIL rst_mid: got %b expected 0000000", {dm_bus.req, stall, memwb_valid, dm_bus.be}); end
    checks++; if (dm_bus.addr !== 32'd0 || memwb_exc !== 2'd0) begin errors++;
      $display("FAIL rst_mid_regs: got addr=%h exc=%b expected 0", dm_bus.addr, memwb_exc); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); dm_bus.ack = 1'b1; dm_bus.rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; dm_bus.ack = 1'b0;
    checks++; if (memwb_valid !== 1'b0 || dm_bus.req !== 1'b0) begin errors++;
      $display("FAIL stray_ack: got valid=%b req=%b expected 0 0", memwb_valid, dm_bus.req); end
    @(negedge clk); clear_inputs();
    $display("txn reset mid-busy: addr=00000400 then stray ack");
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_lb_signed();
    test_lhu();
    test_store_forward();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
